tt_matmul_host_driver: RTL and testbench

//  FPGA-side initiator driving a Tiny Tapeout project's pins (ui_in/uo_out/uio) from the board.

---
 rtl/tt_matmul_host_driver.sv | 178 +++++++++++++++++
 tb/tb_tt_matmul_host_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_matmul_host_driver.sv
// Board-side initiator for a Tiny Tapeout matmul project: streams operand bytes over ui_in
// with a load strobe, pulses start, waits for the project's done flag and reads results back.
module tt_matmul_host_driver #(
  parameter int N_OPS   = 8,
  parameter int N_RES   = 4,
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [8*N_OPS-1:0] op_data,
  output logic [8*N_RES-1:0] res_data,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [7:0]         ui_in,
  input  logic [7:0]         uo_out,
  input  logic [7:0]         uio_in,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(3 * HOLD + 1);
  localparam int CW = (TW > PW) ? TW : PW;
  localparam int IW = $clog2(N_OPS + N_RES + 1);

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] HOLD_C   = CW'(HOLD);
  localparam logic [CW-1:0] HOLD_M1  = CW'(HOLD - 1);
  localparam logic [CW-1:0] PH2_C    = CW'(2 * HOLD);
  localparam logic [CW-1:0] PH2_M1   = CW'(2 * HOLD - 1);
  localparam logic [CW-1:0] PH3_M1   = CW'(3 * HOLD - 1);
  localparam logic [CW-1:0] TMO_M1   = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] OPS_LAST = IW'(N_OPS - 1);
  localparam logic [IW-1:0] RES_LAST = IW'(N_RES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [8*N_OPS-1:0] op_q, op_d;
  logic [7:0]         ui_in_q, ui_in_d;
  logic [8*N_RES-1:0] res_q, res_d;
  logic               tmo_q, tmo_d;
  logic [2:0]         strb_q, strb_d;
  logic [1:0]         sync_q, sync_d;
  logic               unused_uio_s;

  // Next-state, datapath and strobe computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    op_d    = op_q;
    ui_in_d = ui_in_q;
    res_d   = res_q;
    tmo_d   = tmo_q;
    sync_d  = {sync_q[0], uio_in[7]};
    // Strobes are registered from the current phase, so they trail ui_in by one cycle.
    strb_d[0] = (state_q == S_LOAD)  && (cnt_q < HOLD_C);
    strb_d[1] = (state_q == S_START) && (cnt_q < HOLD_C);
    strb_d[2] = (state_q == S_READ)  && (cnt_q >= HOLD_C) && (cnt_q < PH2_C);
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_LOAD;
          cnt_d   = CNT_ZERO;
          idx_d   = '0;
          ui_in_d = op_data[7:0];
          op_d    = op_data >> 4'd8;
          tmo_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (cnt_q == PH2_M1) begin
          cnt_d = CNT_ZERO;
          if (idx_q == OPS_LAST) begin
            state_d = S_START;
          end else begin
            idx_d   = idx_q + 1'b1;
            ui_in_d = op_q[7:0];
            op_d    = op_q >> 4'd8;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == PH2_M1) begin
          state_d = S_WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // The first WAIT cycle is not trusted, so a flag already high costs two cycles.
        if (sync_q[1] && (cnt_q != CNT_ZERO)) begin
          state_d = S_READ;
          cnt_d   = CNT_ZERO;
          idx_d   = '0;
        end else if (cnt_q == TMO_M1) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (cnt_q == HOLD_M1) begin
          res_d[{idx_q, 3'b000} +: 8] = uo_out;
        end else begin
          res_d = res_q;
        end
        if (cnt_q == PH3_M1) begin
          cnt_d = CNT_ZERO;
          if (idx_q == RES_LAST) begin
            state_d = S_FIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= '0;
      op_q    <= '0;
      ui_in_q <= 8'h00;
      res_q   <= '0;
      tmo_q   <= 1'b0;
      strb_q  <= 3'b000;
      sync_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      ui_in_q <= ui_in_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
      strb_q  <= strb_d;
      sync_q  <= sync_d;
    end
  end

  assign unused_uio_s = ^uio_in[6:0];
  assign ui_in        = ui_in_q;
  assign uio_out      = {5'b00000, strb_q};
  assign uio_oe       = 8'b0000_0111;
  assign res_data     = res_q;
  assign timeout_err  = tmo_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
endmodule

// File: tb/tb_tt_matmul_host_driver.sv
// Bench for tt_matmul_host_driver: a behavioural Tiny Tapeout project model on the pins of a
// default build and a HOLD=1/N_OPS=2/N_RES=1 build, with randomized operands and results.
module tb_tt_matmul_host_driver;
  localparam int H0 = 2, NO0 = 8, NR0 = 4, TO0 = 1024;
  localparam int H1 = 1, NO1 = 2, NR1 = 1, TO1 = 1024;
  localparam int LIM = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        go0, go1;
  logic [63:0] op0;
  logic [15:0] op1;
  logic [31:0] res0;
  logic [7:0]  res1;
  logic        busy0, busy1, done0, done1, terr0, terr1;
  logic [7:0]  ui0, ui1, uo0, uo1, uioi0, uioi1, uioo0, uioo1, oe0, oe1;

  // project model state, index 0 = default build, 1 = small build
  logic [7:0] uo_m [2];
  logic       fl [2];
  int         w [2][3];
  logic [2:0] prv [2];
  logic [7:0] prv_ui [2];
  logic [7:0] rx_b [2][16];
  int         rx_n [2];
  logic [7:0] pres [2][4];
  int         rptr [2];
  int         cd [2];
  int         arm [2];
  int         dc [2];

  int tests = 0;
  int fails = 0;

  assign uo0   = uo_m[0];
  assign uo1   = uo_m[1];
  assign uioi0 = {fl[0], 7'b0000000};
  assign uioi1 = {fl[1], 7'b0000000};

  tt_matmul_host_driver #(.N_OPS(NO0), .N_RES(NR0), .HOLD(H0), .TIMEOUT(TO0)) dut0 (
    .clk(clk), .rst_n(rst_n), .go(go0), .op_data(op0), .res_data(res0), .busy(busy0),
    .done(done0), .timeout_err(terr0), .ui_in(ui0), .uo_out(uo0), .uio_in(uioi0),
    .uio_out(uioo0), .uio_oe(oe0));

  tt_matmul_host_driver #(.N_OPS(NO1), .N_RES(NR1), .HOLD(H1), .TIMEOUT(TO1)) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go1), .op_data(op1), .res_data(res1), .busy(busy1),
    .done(done1), .timeout_err(terr1), .ui_in(ui1), .uo_out(uo1), .uio_in(uioi1),
    .uio_out(uioo1), .uio_oe(oe1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_f(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction
  function automatic logic done_f(input int d);
    return (d == 0) ? done0 : done1;
  endfunction
  function automatic logic terr_f(input int d);
    return (d == 0) ? terr0 : terr1;
  endfunction
  function automatic logic [31:0] res_f(input int d);
    return (d == 0) ? res0 : {24'h000000, res1};
  endfunction

  // One pin-level observation of the project: latch bytes on load, answer reads, raise done.
  task automatic step(input int d, input logic [7:0] pins, input logic [7:0] ui,
                      input logic dn, input int hold);
    for (int b = 0; b < 3; b++) begin
      if (pins[b] && !prv[d][b]) begin
        w[d][b] = 1;
        if (b == 0) begin
          check("load_setup", ui, prv_ui[d]);
          if (rx_n[d] < 16) rx_b[d][rx_n[d]] = ui;
          rx_n[d]++;
        end else if (b == 2) begin
          rptr[d]++;
          uo_m[d] = (rptr[d] < 4) ? pres[d][rptr[d]] : 8'h00;
        end
      end else if (pins[b]) begin
        w[d][b]++;
      end else if (prv[d][b]) begin
        check("strobe_width", w[d][b], hold);
        if (b == 1 && arm[d] >= 0) begin
          cd[d]  = arm[d];
          arm[d] = -1;
        end
      end
    end
    if (cd[d] == 0) begin
      fl[d] = 1'b1;
      cd[d] = -1;
    end else if (cd[d] > 0) begin
      cd[d]--;
    end
    if (dn) dc[d]++;
    prv[d]    = pins[2:0];
    prv_ui[d] = ui;
  endtask

  task automatic tick();
    @(negedge clk);
    step(0, uioo0, ui0, done0, H0);
    step(1, uioo1, ui1, done1, H1);
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      prv[d] = 3'b000; prv_ui[d] = 8'h00; rx_n[d] = 0; rptr[d] = 0;
      cd[d] = -1; arm[d] = -1; dc[d] = 0; fl[d] = 1'b0; uo_m[d] = 8'h00;
      for (int b = 0; b < 3; b++) w[d][b] = 0;
    end
  endtask

  task automatic set_go(input int d, input logic v, input logic [63:0] ops);
    if (d == 0) begin
      go0 = v; op0 = ops;
    end else begin
      go1 = v; op1 = ops[15:0];
    end
  endtask

  // mode 0: done flag rises dly cycles after start falls; 1: never; 2: flag already high
  task automatic run_txn(input int d, input logic [63:0] ops, input logic [31:0] res,
                         input int mode, input int dly, input bit glitch);
    int nops, nres, hold, tmo, lat, f_at;
    logic [31:0] prev_res, exp_res;
    nops = (d == 0) ? NO0 : NO1;
    nres = (d == 0) ? NR0 : NR1;
    hold = (d == 0) ? H0 : H1;
    tmo  = (d == 0) ? TO0 : TO1;
    prev_res = res_f(d);
    for (int k = 0; k < 4; k++) pres[d][k] = res[8*k +: 8];
    rptr[d] = 0; uo_m[d] = pres[d][0]; rx_n[d] = 0; dc[d] = 0; cd[d] = -1;
    arm[d] = (mode == 0) ? dly : -1;
    fl[d]  = (mode == 2);
    set_go(d, 1'b1, ops);
    tick();
    set_go(d, 1'b0, {$urandom, $urandom});
    lat = 0;
    f_at = -1;
    while (busy_f(d) && lat < LIM) begin
      lat++;
      if (lat == 1) check("terr_clear_on_go", terr_f(d), 1'b0);
      if (fl[d] && f_at < 0) f_at = lat;
      if (glitch && (lat == 3 || done_f(d))) set_go(d, 1'b1, {$urandom, $urandom});
      else if (d == 0) go0 = 1'b0;
      else go1 = 1'b0;
      tick();
    end
    go0 = 1'b0; go1 = 1'b0;
    check("busy_end", busy_f(d), 1'b0);
    if (mode == 1) check("latency_timeout", lat, nops*2*hold + 2*hold + tmo);
    else if (mode == 2) check("latency_held", lat, nops*2*hold + 2*hold + 2 + nres*3*hold + 1);
    else check("latency_after_flag", lat - f_at, 2 + nres*3*hold + 1);
    check("rx_count", rx_n[d], nops);
    for (int k = 0; k < nops; k++) check("rx_byte", rx_b[d][k], ops[8*k +: 8]);
    if (mode == 1) exp_res = prev_res;
    else if (d == 0) exp_res = res;
    else exp_res = {24'h000000, res[7:0]};
    check("res_data", res_f(d), exp_res);
    check("done_count", dc[d], (mode == 1) ? 0 : 1);
    check("timeout_err", terr_f(d), (mode == 1));
    if (glitch) begin
      repeat (6) tick();
      check("no_rerun_busy", busy_f(d), 1'b0);
      check("no_rerun_done", dc[d], 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; go0 = 1'b0; go1 = 1'b0; op0 = 64'h0; op1 = 16'h0;
    model_clear();
    #3;
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_terr", terr0, 1'b0);
    check("rst_uio_out", uioo0, 8'h00);
    check("rst_ui_in", ui0, 8'h00);
    check("rst_res", res0, 32'h0);
    check("uio_oe", oe0, 8'h07);
    check("rst_busy_small", busy1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    run_txn(0, 64'h0807_0605_0403_0201, 32'h4433_2211, 0, 8, 1'b0);
    for (int i = 0; i < 4; i++)
      run_txn(0, {$urandom, $urandom}, $urandom, 0, $urandom_range(4, 40), 1'b0);
    run_txn(0, {$urandom, $urandom}, $urandom, 1, 0, 1'b0);
    run_txn(0, {$urandom, $urandom}, $urandom, 0, $urandom_range(4, 40), 1'b0);
    run_txn(0, {$urandom, $urandom}, $urandom, 0, $urandom_range(4, 40), 1'b1);
    run_txn(0, {$urandom, $urandom}, $urandom, 2, 0, 1'b0);

    // asynchronous reset in the middle of LOAD
    set_go(0, 1'b1, 64'h1122_3344_5566_77A5);
    tick();
    go0 = 1'b0;
    tick();
    check("pre_reset_strobe", uioo0, 8'h01);
    check("pre_reset_ui", ui0, 8'hA5);
    #2 rst_n = 1'b0;
    #1;
    check("async_uio_out", uioo0, 8'h00);
    check("async_ui_in", ui0, 8'h00);
    check("async_busy", busy0, 1'b0);
    check("async_res", res0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (2) tick();
    run_txn(0, {$urandom, $urandom}, $urandom, 0, $urandom_range(4, 40), 1'b0);

    run_txn(1, {48'h0, 16'hBEEF}, 32'h0000_005A, 2, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      run_txn(1, {32'h0, $urandom}, $urandom, 0, $urandom_range(4, 40), 1'b0);
    run_txn(1, {32'h0, $urandom}, $urandom, 1, 0, 1'b0);
    run_txn(1, {32'h0, $urandom}, $urandom, 0, $urandom_range(4, 40), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
